// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_result_t;

  typedef logic [3:0] key_code_t;

  // One scanned frame: classification plus code (code is zero unless FR_SINGLE).
  typedef struct packed {
    frame_result_t result;
    key_code_t     code;
  } frame_t;

  localparam frame_t FrameIdle = '{result: FR_NONE, code: 4'h0};

  // Index of the lowest row that reads low (pressed); 0 if none.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!rows[r]) idx = 2'(r);
    end
    return idx;
  endfunction

  // Number of low rows, saturated at 2 (2 means "two or more").
  function automatic logic [1:0] count_low_sat(input logic [NUM_ROWS-1:0] rows);
    int unsigned n;
    n = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows[r]) n++;
    end
    return (n >= 2) ? 2'd2 : 2'(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability filter chain; resets to the idle (released) level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: column rotation, frame classification, debounce and a
// one-entry press holding register read and acknowledged by software.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic            s00_axi_aclk,
  input  logic            s00_axi_aresetn,
  output logic [3:0]      col_out,
  input  logic [3:0]      row_in,
  input  logic            key_ack,
  output logic [3:0]      key_code,
  output logic            key_ready,
  output logic            key_down,
  output logic            multi_key,
  output logic            overrun
);

  localparam int unsigned CntW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned StabW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0]  CntMax  = CntW'(SCAN_DIV - 1);
  localparam logic [StabW-1:0] StabMax = StabW'(DEBOUNCE_FRAMES - 1);

  logic [3:0]       row_s;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       acc_n_q, acc_n_d;
  key_code_t        acc_code_q, acc_code_d;
  frame_t           prev_q, prev_d;
  logic [StabW-1:0] stable_q, stable_d;
  frame_t           accepted_q, accepted_d;
  key_code_t        key_code_q, key_code_d;
  logic             key_ready_q, key_ready_d;
  logic             overrun_q, overrun_d;

  logic       tick;
  logic       frame_close;
  logic [1:0] col_n;
  logic [2:0] sum_raw;
  logic [1:0] tot;
  key_code_t  code_next;
  frame_t     new_frame;
  logic       accept;
  logic       press_event;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_row_sync (
    .clk_i  (s00_axi_aclk),
    .rst_ni (s00_axi_aresetn),
    .d_i    (row_in),
    .q_o    (row_s)
  );

  assign tick        = (cnt_q == CntMax);
  assign frame_close = tick && (col_q == 2'd3);
  assign col_n       = count_low_sat(row_s);
  assign sum_raw     = {1'b0, acc_n_q} + {1'b0, col_n};
  assign tot         = (sum_raw >= 3'd2) ? 2'd2 : sum_raw[1:0];
  // The first low row seen in the frame defines the code.
  assign code_next   = (acc_n_q == 2'd0 && col_n != 2'd0) ? {lowest_low_row(row_s), col_q}
                                                         : acc_code_q;

  // Dwell counter and column rotation.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    col_d = col_q;
    if (tick) begin
      cnt_d = '0;
      col_d = col_q + 2'd1;
    end
  end

  // Frame accumulation across columns and stability tracking at frame close.
  always_comb begin
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    new_frame  = FrameIdle;
    unique case (tot)
      2'd0:    new_frame = FrameIdle;
      2'd1:    new_frame = '{result: FR_SINGLE, code: code_next};
      default: new_frame = '{result: FR_MULTI, code: 4'h0};
    endcase
    if (frame_close) begin
      acc_n_d    = 2'd0;
      acc_code_d = 4'h0;
      prev_d     = new_frame;
      if (new_frame == prev_q) begin
        stable_d = (stable_q == StabMax) ? stable_q : stable_q + 1'b1;
      end else begin
        stable_d = '0;
      end
    end else if (tick) begin
      acc_n_d    = tot;
      acc_code_d = code_next;
    end
  end

  // Acceptance runs one clock after frame close and fires once per change.
  assign accept      = (stable_q == StabMax) && (prev_q != accepted_q);
  assign press_event = accept && (prev_q.result == FR_SINGLE);
  assign accepted_d  = accept ? prev_q : accepted_q;

  // Holding register: a press event takes priority over a simultaneous ack.
  always_comb begin
    key_code_d  = key_code_q;
    key_ready_d = key_ready_q;
    overrun_d   = overrun_q;
    if (press_event) begin
      key_code_d  = prev_q.code;
      key_ready_d = 1'b1;
      if (key_ack)          overrun_d = 1'b0;
      else if (key_ready_q) overrun_d = 1'b1;
    end else if (key_ack && key_ready_q) begin
      key_ready_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cnt_q       <= '0;
      col_q       <= 2'd0;
      acc_n_q     <= 2'd0;
      acc_code_q  <= 4'h0;
      prev_q      <= FrameIdle;
      stable_q    <= '0;
      accepted_q  <= FrameIdle;
      key_code_q  <= 4'h0;
      key_ready_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      accepted_q  <= accepted_d;
      key_code_q  <= key_code_d;
      key_ready_q <= key_ready_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_ready = key_ready_q;
  assign overrun   = overrun_q;
  assign key_down  = (accepted_q.result == FR_SINGLE);
  assign multi_key = (accepted_q.result == FR_MULTI);

endmodule
